axil_console_uart: RTL and testbench



---
 rtl/axil_console_pkg.sv | 17 +
 rtl/console_tx_fifo.sv | 48 ++++
 rtl/axil_console_uart.sv | 222 ++++++++++++++++++++++
 tb/tb_axil_console_uart.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_console_pkg.sv
// Shared constants and types for the AXI4-Lite console UART.
package axil_console_pkg;

   localparam logic [1:0] REG_TXDATA = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_TEST   = 2'd2;

   localparam int unsigned STAT_FULL      = 0;
   localparam int unsigned STAT_EMPTY     = 1;
   localparam int unsigned STAT_BUSY      = 2;
   localparam int unsigned STAT_LEVEL_LSB = 8;

   localparam logic [31:0] DEFAULT_TEST_MAGIC = 32'd123456789;

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} uart_state_t;

endpackage

// File: rtl/console_tx_fifo.sv
// Synchronous FIFO holding bytes queued for the console transmitter.
module console_tx_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 8,
   localparam int unsigned PW = $clog2(DEPTH),
   localparam int unsigned LW = PW + 1
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [LW-1:0]    level
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [LW-1:0]    level_q;
   logic             do_push, do_pop;

   assign full    = (level_q == LW'(DEPTH));
   assign empty   = (level_q == '0);
   assign level   = level_q;
   assign rdata   = mem[rd_ptr_q];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
         level_q <= level_q + LW'(do_push) - LW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/axil_console_uart.sv
// AXI4-Lite console peripheral: buffered 8N1 transmitter, status register and
// sticky tests-passed flag.
module axil_console_uart
   import axil_console_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned FIFO_DEPTH   = 8,
   parameter logic [31:0] TEST_MAGIC   = DEFAULT_TEST_MAGIC
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        s_axi_awvalid,
   output logic        s_axi_awready,
   input  logic [31:0] s_axi_awaddr,
   input  logic [2:0]  s_axi_awprot,
   input  logic        s_axi_wvalid,
   output logic        s_axi_wready,
   input  logic [31:0] s_axi_wdata,
   input  logic [3:0]  s_axi_wstrb,
   output logic        s_axi_bvalid,
   input  logic        s_axi_bready,
   input  logic        s_axi_arvalid,
   output logic        s_axi_arready,
   input  logic [31:0] s_axi_araddr,
   input  logic [2:0]  s_axi_arprot,
   output logic        s_axi_rvalid,
   input  logic        s_axi_rready,
   output logic [31:0] s_axi_rdata,
   output logic        uart_tx,
   output logic        tests_passed,
   output logic        irq_tx_empty
);

   localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

   logic          awready_q, wready_q, bvalid_q, aw_q, w_q;
   logic [1:0]    aw_addr_q;
   logic [31:0]   wdata_q;
   logic [3:0]    wstrb_q;
   logic          arready_q, rvalid_q, tests_passed_q, irq_q;
   logic [31:0]   rdata_q, rd_word;
   logic          aw_hs, w_hs, ar_hs, have_aw, have_w, txdata_push, wr_exec;
   logic          aw_d, w_d, bvalid_d, awready_d, wready_d, rvalid_d, arready_d;
   logic [1:0]    wr_addr;
   logic [31:0]   wr_data;
   logic [3:0]    wr_strb;
   logic          fifo_pop, fifo_full, fifo_empty, tx_busy;
   logic [7:0]    fifo_rdata;
   logic [LW-1:0] fifo_level;
   uart_state_t   state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    shift_q, shift_d;
   logic          unused_bits;

   assign unused_bits = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[31:4], s_axi_awaddr[1:0],
                          s_axi_araddr[31:4], s_axi_araddr[1:0]};

   assign aw_hs   = s_axi_awvalid && awready_q;
   assign w_hs    = s_axi_wvalid && wready_q;
   assign ar_hs   = s_axi_arvalid && arready_q;
   assign have_aw = aw_q || aw_hs;
   assign have_w  = w_q || w_hs;
   assign wr_addr = aw_q ? aw_addr_q : s_axi_awaddr[3:2];
   assign wr_data = w_q ? wdata_q : s_axi_wdata;
   assign wr_strb = w_q ? wstrb_q : s_axi_wstrb;

   // A TXDATA push into a full FIFO holds the write (and its latches) until space opens.
   assign txdata_push = (wr_addr == REG_TXDATA) && wr_strb[0];
   assign wr_exec     = have_aw && have_w && !bvalid_q && !(txdata_push && fifo_full);
   assign aw_d        = have_aw && !wr_exec;
   assign w_d         = have_w && !wr_exec;
   assign bvalid_d    = wr_exec || (bvalid_q && !s_axi_bready);
   assign awready_d   = s_axi_awvalid && !awready_q && !aw_d && !bvalid_d;
   assign wready_d    = s_axi_wvalid && !wready_q && !w_d && !bvalid_d;
   assign rvalid_d    = ar_hs || (rvalid_q && !s_axi_rready);
   assign arready_d   = s_axi_arvalid && !arready_q && !rvalid_d;

   always_comb begin
      rd_word = '0;
      unique case (s_axi_araddr[3:2])
         REG_STATUS: begin
            rd_word[STAT_FULL]                 = fifo_full;
            rd_word[STAT_EMPTY]                = fifo_empty;
            rd_word[STAT_BUSY]                 = tx_busy;
            rd_word[STAT_LEVEL_LSB +: 8]       = 8'(fifo_level);
         end
         REG_TEST: rd_word[0] = tests_passed_q;
         default:  rd_word = '0;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         awready_q      <= 1'b0;
         wready_q       <= 1'b0;
         bvalid_q       <= 1'b0;
         aw_q           <= 1'b0;
         w_q            <= 1'b0;
         aw_addr_q      <= '0;
         wdata_q        <= '0;
         wstrb_q        <= '0;
         arready_q      <= 1'b0;
         rvalid_q       <= 1'b0;
         rdata_q        <= '0;
         tests_passed_q <= 1'b0;
         irq_q          <= 1'b1;
      end else begin
         awready_q <= awready_d;
         wready_q  <= wready_d;
         bvalid_q  <= bvalid_d;
         aw_q      <= aw_d;
         w_q       <= w_d;
         if (aw_hs) aw_addr_q <= s_axi_awaddr[3:2];
         if (w_hs) begin
            wdata_q <= s_axi_wdata;
            wstrb_q <= s_axi_wstrb;
         end
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         if (ar_hs) rdata_q <= rd_word;
         if (wr_exec && wr_addr == REG_TEST && wr_strb == 4'hF && wr_data == TEST_MAGIC) begin
            tests_passed_q <= 1'b1;
         end
         irq_q <= fifo_empty && !tx_busy;
      end
   end

   console_tx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk    (clk),
      .resetn (resetn),
      .push   (wr_exec && txdata_push),
      .wdata  (wr_data[7:0]),
      .pop    (fifo_pop),
      .rdata  (fifo_rdata),
      .full   (fifo_full),
      .empty  (fifo_empty),
      .level  (fifo_level)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = (cnt_q == '0) ? CNT_MAX : cnt_q - CW'(1);
      idx_d    = idx_q;
      shift_d  = shift_q;
      fifo_pop = 1'b0;
      unique case (state_q)
         StIdle: begin
            cnt_d = CNT_MAX;
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               shift_d  = fifo_rdata;
               state_d  = StStart;
            end
         end
         StStart: begin
            if (cnt_q == '0) begin
               idx_d   = '0;
               state_d = StData;
            end
         end
         StData: begin
            if (cnt_q == '0) begin
               shift_d = shift_q >> 1;
               idx_d   = idx_q + 3'd1;
               if (idx_q == 3'd7) state_d = StStop;
            end
         end
         StStop: begin
            // Chain straight into the next start bit when more data is queued.
            if (cnt_q == '0) begin
               if (!fifo_empty) begin
                  fifo_pop = 1'b1;
                  shift_d  = fifo_rdata;
                  state_d  = StStart;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      tx_busy = (state_q != StIdle);
      unique case (state_q)
         StStart: uart_tx = 1'b0;
         StData:  uart_tx = shift_q[0];
         default: uart_tx = 1'b1;
      endcase
   end

   assign s_axi_awready = awready_q;
   assign s_axi_wready  = wready_q;
   assign s_axi_bvalid  = bvalid_q;
   assign s_axi_arready = arready_q;
   assign s_axi_rvalid  = rvalid_q;
   assign s_axi_rdata   = rdata_q;
   assign tests_passed  = tests_passed_q;
   assign irq_tx_empty  = irq_q;

endmodule

// File: tb/tb_axil_console_uart.sv
// Directed bench for axil_console_uart: AXI-Lite transactions plus a serial monitor.
module tb_axil_console_uart;

   localparam int unsigned CPB = 16;
   localparam logic [31:0] MAGIC = 32'd123456789;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        s_axi_awvalid = 1'b0, s_axi_wvalid = 1'b0, s_axi_bready = 1'b0;
   logic        s_axi_arvalid = 1'b0, s_axi_rready = 1'b0;
   logic [31:0] s_axi_awaddr = '0, s_axi_wdata = '0, s_axi_araddr = '0;
   logic [3:0]  s_axi_wstrb = '0;
   logic        s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid;
   logic [31:0] s_axi_rdata;
   logic        uart_tx, tests_passed, irq_tx_empty;

   int n_tests = 0, n_fail = 0;
   int cyc = 0, rst_cnt = 0, last_b_cyc = 0, frame_err = 0;
   logic       prev_tx = 1'b1;
   logic [7:0] rx_q[$];
   int         rx_t[$];

   axil_console_uart #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (8),
      .TEST_MAGIC   (MAGIC)
   ) dut (
      .clk           (clk),
      .resetn        (resetn),
      .s_axi_awvalid (s_axi_awvalid),
      .s_axi_awready (s_axi_awready),
      .s_axi_awaddr  (s_axi_awaddr),
      .s_axi_awprot  (3'b000),
      .s_axi_wvalid  (s_axi_wvalid),
      .s_axi_wready  (s_axi_wready),
      .s_axi_wdata   (s_axi_wdata),
      .s_axi_wstrb   (s_axi_wstrb),
      .s_axi_bvalid  (s_axi_bvalid),
      .s_axi_bready  (s_axi_bready),
      .s_axi_arvalid (s_axi_arvalid),
      .s_axi_arready (s_axi_arready),
      .s_axi_araddr  (s_axi_araddr),
      .s_axi_arprot  (3'b000),
      .s_axi_rvalid  (s_axi_rvalid),
      .s_axi_rready  (s_axi_rready),
      .s_axi_rdata   (s_axi_rdata),
      .uart_tx       (uart_tx),
      .tests_passed  (tests_passed),
      .irq_tx_empty  (irq_tx_empty)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge resetn) rst_cnt = rst_cnt + 1;

   // Serial monitor: samples mid-bit; frames cut short by a reset are discarded.
   always begin : uart_mon
      int         t0, rc;
      logic [9:0] bits;
      @(negedge clk);
      if (resetn && prev_tx && !uart_tx) begin
         t0 = cyc;
         rc = rst_cnt;
         repeat (CPB / 2) @(negedge clk);
         bits[0] = uart_tx;
         for (int k = 1; k < 10; k++) begin
            repeat (CPB) @(negedge clk);
            bits[k] = uart_tx;
         end
         if (rc == rst_cnt) begin
            if (!bits[0] && bits[9]) begin
               rx_q.push_back(bits[8:1]);
               rx_t.push_back(t0);
            end else begin
               frame_err++;
            end
         end
      end
      prev_tx = uart_tx;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_aw(input logic [31:0] addr, input int dly);
      repeat (dly) tick();
      s_axi_awaddr  = addr;
      s_axi_awvalid = 1'b1;
      for (int n = 0; n < 500; n++) begin
         @(negedge clk);
         if (s_axi_awready) begin
            tick();
            s_axi_awvalid = 1'b0;
            return;
         end
         tick();
      end
      check_eq("aw_timeout", 32'(s_axi_awready), 1);
      s_axi_awvalid = 1'b0;
   endtask

   task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input int dly);
      repeat (dly) tick();
      s_axi_wdata  = data;
      s_axi_wstrb  = strb;
      s_axi_wvalid = 1'b1;
      for (int n = 0; n < 500; n++) begin
         @(negedge clk);
         if (s_axi_wready) begin
            tick();
            s_axi_wvalid = 1'b0;
            return;
         end
         tick();
      end
      check_eq("w_timeout", 32'(s_axi_wready), 1);
      s_axi_wvalid = 1'b0;
   endtask

   task automatic send_ar(input logic [31:0] addr);
      s_axi_araddr  = addr;
      s_axi_arvalid = 1'b1;
      for (int n = 0; n < 500; n++) begin
         @(negedge clk);
         if (s_axi_arready) begin
            tick();
            s_axi_arvalid = 1'b0;
            return;
         end
         tick();
      end
      check_eq("ar_timeout", 32'(s_axi_arready), 1);
      s_axi_arvalid = 1'b0;
   endtask

   // Returns at the negedge where bvalid is first seen.
   task automatic wait_b(output int bcyc);
      bcyc = -1;
      for (int n = 0; n < 2000; n++) begin
         @(negedge clk);
         if (s_axi_bvalid) begin
            bcyc       = cyc;
            last_b_cyc = cyc;
            return;
         end
      end
      check_eq("b_timeout", 32'(s_axi_bvalid), 1);
   endtask

   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output int lat);
      int t0, bc;
      t0 = cyc;
      s_axi_bready = 1'b1;
      fork
         send_aw(addr, 0);
         send_w(data, strb, 0);
      join
      wait_b(bc);
      tick();
      lat = bc - t0;
   endtask

   task automatic axi_read(input logic [31:0] addr, output logic [31:0] data);
      s_axi_rready = 1'b0;
      data = '0;
      send_ar(addr);
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         if (s_axi_rvalid) begin
            data = s_axi_rdata;
            s_axi_rready = 1'b1;
            tick();
            s_axi_rready = 1'b0;
            return;
         end
         tick();
      end
      check_eq("r_timeout", 32'(s_axi_rvalid), 1);
   endtask

   task automatic wait_rx(input int n);
      for (int i = 0; i < 4000 && rx_q.size() < n; i++) tick();
      check_eq("rx_count", 32'(rx_q.size()), 32'(n));
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 4000 && !irq_tx_empty; i++) tick();
      check_eq("idle", 32'(irq_tx_empty), 1);
   endtask

   initial begin
      int          lat, bc, t_frame, b0, gap_bad, lows;
      logic [31:0] rd;

      // Reset state
      #12;
      check_eq("rst_awready", 32'(s_axi_awready), 0);
      check_eq("rst_bvalid", 32'(s_axi_bvalid), 0);
      check_eq("rst_rvalid", 32'(s_axi_rvalid), 0);
      check_eq("rst_rdata", s_axi_rdata, 0);
      check_eq("rst_uart_tx", 32'(uart_tx), 1);
      check_eq("rst_passed", 32'(tests_passed), 0);
      check_eq("rst_irq", 32'(irq_tx_empty), 1);
      @(negedge clk);
      resetn = 1'b1;
      tick();

      // TEST register: partial strobe ignored, magic sets sticky flag
      axi_write(32'h8, MAGIC, 4'b0111, lat);
      check_eq("t4_partial_strb", 32'(tests_passed), 0);
      axi_read(32'h8, rd);
      check_eq("t4_read_zero", rd, 0);
      axi_write(32'h8, MAGIC, 4'hF, lat);
      check_eq("t4_magic_set", 32'(tests_passed), 1);
      axi_read(32'h8, rd);
      check_eq("t4_read_one", rd, 1);
      axi_write(32'h8, 32'h0, 4'hF, lat);
      check_eq("t4_sticky", 32'(tests_passed), 1);
      axi_read(32'h0, rd);
      check_eq("txdata_read", rd, 0);
      axi_read(32'hC, rd);
      check_eq("reg3_read", rd, 0);
      axi_read(32'h4, rd);
      check_eq("status_idle", rd, 32'h0000_0002);

      // Single byte 0x41
      b0 = rx_q.size();
      axi_write(32'h0, 32'h41, 4'b0001, lat);
      check_eq("t1_b_latency", 32'(lat), 2);
      @(negedge clk);
      check_eq("t1_irq_low", 32'(irq_tx_empty), 0);
      for (int i = 0; i < 400 && !irq_tx_empty; i++) @(negedge clk);
      bc = cyc;
      tick();
      wait_rx(b0 + 1);
      check_eq("t1_byte", 32'(rx_q[b0]), 32'h41);
      check_eq("t1_start_delay", 32'(rx_t[b0] - last_b_cyc), 1);
      // irq re-asserts one cycle after the 160-cycle frame ends
      check_eq("t1_frame_len", 32'(bc - rx_t[b0]), 161);

      // Ten writes: first byte leaves the FIFO at once, bytes 2..9 fill it, the tenth stalls
      wait_idle();
      b0 = rx_q.size();
      for (int i = 0; i < 9; i++) axi_write(32'h0, 32'h10 + 32'(i), 4'b0001, lat);
      fork
         axi_write(32'h0, 32'h19, 4'b0001, lat);
         begin
            repeat (20) tick();
            check_eq("t2_stall_bvalid", 32'(s_axi_bvalid), 0);
            axi_read(32'h4, rd);
            check_eq("t2_status_full", rd, 32'h0000_0805);
         end
      join
      wait_rx(b0 + 1);
      check_eq("t2_b_after_pop", 32'(last_b_cyc - rx_t[b0]), 161);
      wait_rx(b0 + 10);
      gap_bad = 0;
      for (int i = 0; i < 10; i++) begin
         check_eq("t2_byte", 32'(rx_q[b0 + i]), 32'h10 + 32'(i));
         if (i > 0 && rx_t[b0 + i] - rx_t[b0 + i - 1] != 10 * CPB) gap_bad++;
      end
      check_eq("t2_gaps", 32'(gap_bad), 0);

      // AW before W, then W before AW, with bready held low
      wait_idle();
      b0 = rx_q.size();
      s_axi_bready = 1'b0;
      fork
         send_aw(32'h0, 0);
         send_w(32'h55, 4'b0001, 3);
      join
      wait_b(bc);
      for (int i = 0; i < 4; i++) begin
         tick();
         @(negedge clk);
         check_eq("t3a_b_hold", 32'(s_axi_bvalid), 1);
      end
      s_axi_bready = 1'b1;
      tick();
      s_axi_bready = 1'b0;
      @(negedge clk);
      check_eq("t3a_b_done", 32'(s_axi_bvalid), 0);
      tick();
      fork
         send_aw(32'h0, 3);
         send_w(32'h66, 4'b0001, 0);
      join
      wait_b(bc);
      s_axi_awaddr  = 32'h0;
      s_axi_awvalid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         @(negedge clk);
         check_eq("t3b_b_hold", 32'(s_axi_bvalid), 1);
         check_eq("t3b_no_aw", 32'(s_axi_awready), 0);
      end
      s_axi_bready = 1'b1;
      tick();
      s_axi_bready = 1'b0;
      fork
         send_aw(32'h0, 0);
         send_w(32'h77, 4'b0001, 0);
      join
      s_axi_bready = 1'b1;
      wait_b(bc);
      tick();
      s_axi_bready = 1'b0;
      wait_rx(b0 + 3);
      check_eq("t3_byte0", 32'(rx_q[b0]), 32'h55);
      check_eq("t3_byte1", 32'(rx_q[b0 + 1]), 32'h66);
      check_eq("t3_byte2", 32'(rx_q[b0 + 2]), 32'h77);
      wait_idle();
      repeat (20) tick();
      check_eq("t3_no_extra", 32'(rx_q.size()), 32'(b0 + 3));

      // STATUS read held across the end of a frame
      axi_write(32'h0, 32'h5A, 4'b0001, lat);
      t_frame = last_b_cyc + 1;
      while (cyc < t_frame + 155) tick();
      s_axi_rready = 1'b0;
      send_ar(32'h4);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_eq("t5_rvalid_hold", 32'(s_axi_rvalid), 1);
         check_eq("t5_rdata_hold", s_axi_rdata, 32'h0000_0006);
         tick();
      end
      check_eq("t5_irq_after", 32'(irq_tx_empty), 1);
      s_axi_rready = 1'b1;
      tick();
      s_axi_rready = 1'b0;
      axi_read(32'h4, rd);
      check_eq("t5_status_after", rd, 32'h0000_0002);

      // Reset in the middle of a data bit with bytes queued
      wait_idle();
      b0 = rx_q.size();
      axi_write(32'h0, 32'hA1, 4'b0001, lat);
      t_frame = last_b_cyc + 1;
      axi_write(32'h0, 32'hA2, 4'b0001, lat);
      axi_write(32'h0, 32'hA3, 4'b0001, lat);
      while (cyc < t_frame + 40) tick();
      #2;
      check_eq("t6_pre_tx", 32'(uart_tx), 0);
      resetn = 1'b0;
      #1;
      check_eq("t6_rst_tx", 32'(uart_tx), 1);
      check_eq("t6_rst_irq", 32'(irq_tx_empty), 1);
      check_eq("t6_rst_passed", 32'(tests_passed), 0);
      repeat (3) tick();
      #2;
      resetn = 1'b1;
      tick();
      axi_read(32'h4, rd);
      check_eq("t6_status", rd, 32'h0000_0002);
      lows = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (!uart_tx) lows++;
      end
      check_eq("t6_tx_quiet", 32'(lows), 0);
      check_eq("t6_no_frames", 32'(rx_q.size()), 32'(b0));
      check_eq("frame_errors", 32'(frame_err), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
